// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin burst arbiter.
package arb_pkg;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  // Widest one-hot vector onehot_to_bin accepts; narrower vectors are zero-extended.
  localparam int unsigned MaxN = 64;

  function automatic int unsigned onehot_to_bin(input logic [MaxN-1:0] oh);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < MaxN; i++) begin
      if (oh[i]) res = res | i;
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr, wrapping mod N.
module rr_prio_pick #(
  parameter  int unsigned N    = 4,
  localparam int unsigned ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    pick
);

  always_comb begin
    logic        found;
    int unsigned idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_burst_arbiter.sv
// N-way round-robin arbiter that holds a registered one-hot grant for a whole burst.
module rr_burst_arbiter
  import arb_pkg::*;
#(
  parameter  int unsigned N         = 4,
  parameter  int unsigned MAX_BURST = 8,
  localparam int unsigned ID_W      = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    req_last,
  input  logic            out_ready,
  output logic [N-1:0]    grant,
  output logic            grant_valid,
  output logic [ID_W-1:0] grant_id,
  output logic            beat
);

  localparam int unsigned CntW = $clog2(MAX_BURST) + 1;

  arb_state_t      r_state, w_state_d;
  logic [N-1:0]    r_grant, w_grant_d;
  logic [ID_W-1:0] r_ptr, w_ptr_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;

  logic [ID_W-1:0] w_gid;
  logic [ID_W-1:0] w_ptr_next;
  logic [ID_W-1:0] w_pick_ptr;
  logic [N-1:0]    w_pick;
  logic            w_beat;
  logic            w_release;

  assign w_gid      = ID_W'(onehot_to_bin(MaxN'(r_grant)));
  assign w_ptr_next = (w_gid == ID_W'(N - 1)) ? '0 : w_gid + ID_W'(1);
  assign w_beat     = (|r_grant) & out_ready & req[w_gid];

  // On release the releasing index drops to lowest priority, so it only wins if alone.
  assign w_pick_ptr = (r_state == BUSY) ? w_ptr_next : r_ptr;

  rr_prio_pick #(
    .N(N)
  ) u_pick (
    .req  (req),
    .ptr  (w_pick_ptr),
    .pick (w_pick)
  );

  always_comb begin
    w_state_d = r_state;
    w_grant_d = r_grant;
    w_ptr_d   = r_ptr;
    w_cnt_d   = r_cnt;
    w_release = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (|req) begin
          w_grant_d = w_pick;
          w_cnt_d   = '0;
          w_state_d = BUSY;
        end
      end
      BUSY: begin
        w_release = (w_beat & (req_last[w_gid] | (r_cnt == CntW'(MAX_BURST - 1))))
                    | !req[w_gid];
        if (w_release) begin
          w_ptr_d   = w_ptr_next;
          w_grant_d = w_pick;
          w_cnt_d   = '0;
          w_state_d = (|w_pick) ? BUSY : IDLE;
        end else if (w_beat) begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end
      default: begin
        w_state_d = IDLE;
        w_grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_grant <= w_grant_d;
      r_ptr   <= w_ptr_d;
      r_cnt   <= w_cnt_d;
    end
  end

  assign grant       = r_grant;
  assign grant_valid = |r_grant;
  assign grant_id    = w_gid;
  assign beat        = w_beat;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Directed self-checking bench for rr_burst_arbiter (N=4, MAX_BURST=8).
module tb_rr_burst_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] req_last;
  logic       out_ready;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic       beat;

  int n_checks;
  int n_pass;

  rr_burst_arbiter #(
    .N         (4),
    .MAX_BURST (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_last    (req_last),
    .out_ready   (out_ready),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .beat        (beat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    req = 4'b0000; req_last = 4'b0000; out_ready = 1'b0; rst_n = 1'b0;
    #1;
    n_checks++;
    if (grant !== 4'b0000) $display("FAIL reset_grant: got %b expected 0000", grant);
    else n_pass++;
    n_checks++;
    if (grant_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", grant_valid);
    else n_pass++;
    n_checks++;
    if (grant_id !== 2'd0) $display("FAIL reset_id: got %0d expected 0", grant_id);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    step;
    n_checks++;
    if (grant !== 4'b0000 || beat !== 1'b0)
      $display("FAIL idle_no_req: got grant=%b beat=%b expected 0000/0", grant, beat);
    else n_pass++;
  endtask

  task automatic test_rotate_all;
    logic [3:0] exp_seq [5];
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset;
    req = 4'b1111; req_last = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step;
      n_checks++;
      if (grant !== exp_seq[i] || grant_valid !== 1'b1)
        $display("FAIL rotate_%0d: got grant=%b valid=%b expected %b/1",
                 i, grant, grant_valid, exp_seq[i]);
      else n_pass++;
    end
  endtask

  task automatic test_max_burst;
    do_reset;
    req = 4'b0011; req_last = 4'b0000; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step;
      n_checks++;
      if (grant !== 4'b0001) $display("FAIL burst0_%0d: got %b expected 0001", i, grant);
      else n_pass++;
    end
    for (int i = 0; i < 8; i++) begin
      step;
      n_checks++;
      if (grant !== 4'b0010) $display("FAIL burst1_%0d: got %b expected 0010", i, grant);
      else n_pass++;
    end
    step;
    n_checks++;
    if (grant !== 4'b0001) $display("FAIL burst_wrap: got %b expected 0001", grant);
    else n_pass++;
    for (int i = 0; i < 7; i++) step;
    n_checks++;
    if (grant !== 4'b0001) $display("FAIL burst_pre_limit: got %b expected 0001", grant);
    else n_pass++;
    // Eighth beat also carries req_last: must release exactly once.
    req_last = 4'b0011;
    step;
    n_checks++;
    if (grant !== 4'b0010) $display("FAIL single_release: got %b expected 0010", grant);
    else n_pass++;
    req_last = 4'b0000;
    step;
    n_checks++;
    if (grant !== 4'b0010) $display("FAIL hold_after_limit: got %b expected 0010", grant);
    else n_pass++;
  endtask

  task automatic test_stall;
    do_reset;
    req = 4'b0010; req_last = 4'b0010; out_ready = 1'b0;
    step;
    n_checks++;
    if (grant !== 4'b0010) $display("FAIL stall_grant: got %b expected 0010", grant);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      step;
      n_checks++;
      if (grant !== 4'b0010 || beat !== 1'b0)
        $display("FAIL stall_%0d: got grant=%b beat=%b expected 0010/0", i, grant, beat);
      else n_pass++;
    end
    req = 4'b0011; out_ready = 1'b1;
    #1;
    n_checks++;
    if (beat !== 1'b1) $display("FAIL stall_beat: got %b expected 1", beat);
    else n_pass++;
    step;
    n_checks++;
    if (grant !== 4'b0001) $display("FAIL stall_release: got %b expected 0001", grant);
    else n_pass++;
  endtask

  task automatic test_abort;
    do_reset;
    req = 4'b0100; req_last = 4'b0000; out_ready = 1'b0;
    step;
    n_checks++;
    if (grant !== 4'b0100) $display("FAIL abort_grant: got %b expected 0100", grant);
    else n_pass++;
    req = 4'b1001;
    step;
    n_checks++;
    if (grant !== 4'b1000 || grant_id !== 2'd3)
      $display("FAIL abort_next: got grant=%b id=%0d expected 1000/3", grant, grant_id);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    do_reset;
    req = 4'b0001; req_last = 4'b0001; out_ready = 1'b1;
    step;
    n_checks++;
    if (grant !== 4'b0001) $display("FAIL sole_first: got %b expected 0001", grant);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      step;
      n_checks++;
      if (grant !== 4'b0001 || grant_valid !== 1'b1)
        $display("FAIL sole_%0d: got grant=%b valid=%b expected 0001/1", i, grant, grant_valid);
      else n_pass++;
    end
    req = 4'b0011;
    step;
    n_checks++;
    if (grant !== 4'b0010) $display("FAIL sole_handoff: got %b expected 0010", grant);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    do_reset;
    req = 4'b1111; req_last = 4'b1111; out_ready = 1'b1;
    step;
    step;
    n_checks++;
    if (grant !== 4'b0010) $display("FAIL mid_pre: got %b expected 0010", grant);
    else n_pass++;
    req_last = 4'b0000;
    step;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_id !== 2'd0)
      $display("FAIL mid_async: got grant=%b valid=%b id=%0d expected 0000/0/0",
               grant, grant_valid, grant_id);
    else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step;
    n_checks++;
    if (grant !== 4'b0001) $display("FAIL mid_regrant: got %b expected 0001", grant);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset;
    test_rotate_all;
    test_max_burst;
    test_stall;
    test_abort;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
